// File: rtl/alu_hs.sv
// Pipelined-output ALU with valid/ready handshakes on both sides.
// Single-cycle ops register in one edge; MULU runs a WIDTH-step shift-add sequence.
module alu_hs #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_EQ   = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_MULU = 4'd12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_y_hi;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_err;

    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_ld_single;
    logic             w_ld_mul;
    logic             w_mul_step;
    logic             w_mul_done;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_res;
    logic             w_res_z;
    logic             w_res_c;
    logic             w_res_v;
    logic             w_res_err;

    logic [PW-1:0]    w_acc_nxt;
    logic [WIDTH-1:0] w_prod_lo;
    logic [WIDTH-1:0] w_prod_hi;

    // Accept only when idle and the output slot is free or being drained this cycle.
    assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_ld_single = 1'b0;
        w_ld_mul    = 1'b0;
        w_mul_step  = 1'b0;
        w_mul_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (op == OP_MULU) begin
                        w_ld_mul    = 1'b1;
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_ld_single = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                w_mul_step = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_mul_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_sh   = b[SHW-1:0];

    // Single-cycle result and flags, computed from the incoming operands
    always_comb begin
        w_res     = '0;
        w_res_c   = 1'b0;
        w_res_v   = 1'b0;
        w_res_err = 1'b0;
        case (op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_res_c = w_sum[WIDTH];
                w_res_v = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_res_c = w_diff[WIDTH];
                w_res_v = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_NOT:  w_res = ~a;
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_SLT:  w_res = WIDTH'($signed(a) < $signed(b));
            OP_EQ:   w_res = WIDTH'(a == b);
            OP_SLTU: w_res = WIDTH'(a < b);
            OP_SHL:  w_res = a << w_sh;
            OP_SHR:  w_res = a >> w_sh;
            OP_SRA:  w_res = $unsigned($signed(a) >>> w_sh);
            default: w_res_err = 1'b1;
        endcase
        w_res_z = !w_res_err && (w_res == '0);
    end

    // The final step's partial product is the full product loaded on completion.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_lo = w_acc_nxt[WIDTH-1:0];
    assign w_prod_hi = w_acc_nxt[PW-1:WIDTH];

    // Shift-add multiplier registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_ld_mul) begin
            r_mcand  <= PW'(a);
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
        end else if (w_mul_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    // Output buffer: loads on a result, otherwise holds data and tracks consumption
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_y_hi      <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_mul_done) begin
                r_y     <= w_prod_lo;
                r_y_hi  <= w_prod_hi;
                r_zero  <= (w_acc_nxt == '0);
                r_carry <= 1'b0;
                r_ovf   <= (w_prod_hi != '0);
                r_err   <= 1'b0;
            end else if (w_ld_single) begin
                r_y     <= w_res;
                r_y_hi  <= '0;
                r_zero  <= w_res_z;
                r_carry <= w_res_c;
                r_ovf   <= w_res_v;
                r_err   <= w_res_err;
            end

            if (w_mul_done || w_ld_single) begin
                r_out_valid <= 1'b1;
            end else if (w_ld_mul || out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_hi      = r_y_hi;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_ovf;
    assign err       = r_err;

    // A multiply in flight never coexists with a pending result
    a_busy_empty: assert property (@(posedge clk) disable iff (!rst)
        (r_state == S_BUSY) |-> !r_out_valid);

    // Stalled results stay put
    a_hold: assert property (@(posedge clk) disable iff (!rst)
        (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_y) && $stable(r_y_hi)));

endmodule

// File: tb/tb_alu_hs.sv
// Bench for alu_hs: directed vectors, hand-computed literals, and an
// arithmetic reference model with a result queue checked every valid cycle.
module tb_alu_hs;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] y;
        logic [W-1:0] y_hi;
        logic         zero;
        logic         carry;
        logic         ovf;
        logic         err;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   t_op;
    logic [W-1:0] t_a;
    logic [W-1:0] t_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;
    res_t q[$];

    alu_hs #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(t_op), .a(t_a), .b(t_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_hi(y_hi), .zero(zero), .carry(carry),
        .overflow(overflow), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic res_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        res_t   r;
        int     ua, ub, sa, sb, sh, v, m, h;
        longint p;
        r  = '0;
        m  = 1 << W;
        h  = 1 << (W - 1);
        ua = int'(x);
        ub = int'(z);
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        sh = ub % W;
        case (o)
            4'd0: begin
                v = ua + ub;
                r.y = W'(v % m);
                r.carry = (v >= m);
                r.ovf = (sa + sb > h - 1) || (sa + sb < -h);
            end
            4'd1: begin
                v = ua - ub;
                r.y = W'((v + m) % m);
                r.carry = (ua < ub);
                r.ovf = (sa - sb > h - 1) || (sa - sb < -h);
            end
            4'd2:  r.y = W'(m - 1 - ua);
            4'd3:  r.y = W'(ua & ub);
            4'd4:  r.y = W'(ua | ub);
            4'd5:  r.y = W'(ua ^ ub);
            4'd6:  r.y = (sa < sb) ? W'(1) : W'(0);
            4'd7:  r.y = (ua == ub) ? W'(1) : W'(0);
            4'd8:  r.y = (ua < ub) ? W'(1) : W'(0);
            4'd9:  r.y = W'((ua << sh) % m);
            4'd10: r.y = W'(ua >> sh);
            4'd11: r.y = W'(sa >>> sh);
            4'd12: begin
                p = longint'(ua) * longint'(ub);
                r.y    = W'(p % longint'(m));
                r.y_hi = W'(p / longint'(m));
                r.ovf  = (r.y_hi != 0);
                r.zero = (p == 0);
            end
            default: r.err = 1'b1;
        endcase
        if (o <= 4'd11) r.zero = (r.y == 0);
        return r;
    endfunction

    // Scoreboard: queue model results on accept, retire on consume
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk1("no_extra_result", q.size() != 0, 1'b1);
                if (q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(t_op, t_a, t_b));
        end
    end

    // Compare visible result against the oldest outstanding model result
    always @(negedge clk) begin
        res_t e;
        if (rst && out_valid) begin
            if (q.size() == 0) begin
                chk1("valid_has_model", 1'b0, 1'b1);
            end else begin
                e = q[0];
                chk8("cmp.y", y, e.y);
                chk8("cmp.y_hi", y_hi, e.y_hi);
                chk1("cmp.zero", zero, e.zero);
                chk1("cmp.carry", carry, e.carry);
                chk1("cmp.overflow", overflow, e.ovf);
                chk1("cmp.err", err, e.err);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // Present one op and hold it until accepted; returns just after the accepting edge
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        bit done;
        done = 1'b0;
        t_op = o; t_a = x; t_b = z;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        chk1("accept_in_time", done, 1'b1);
    endtask

    task automatic wait_out(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk1("out_valid_seen", seen, 1'b1);
    endtask

    task automatic lit_now(input string tag, input logic [W-1:0] ey, input logic [W-1:0] ehi,
                           input logic ez, input logic ec, input logic eo, input logic ee);
        chk1({tag, ".out_valid"}, out_valid, 1'b1);
        chk8({tag, ".y"}, y, ey);
        chk8({tag, ".y_hi"}, y_hi, ehi);
        chk1({tag, ".zero"}, zero, ez);
        chk1({tag, ".carry"}, carry, ec);
        chk1({tag, ".overflow"}, overflow, eo);
        chk1({tag, ".err"}, err, ee);
    endtask

    task automatic chk_cleared(input string tag);
        chk1({tag, ".out_valid"}, out_valid, 1'b0);
        chk8({tag, ".y"}, y, 8'h00);
        chk8({tag, ".y_hi"}, y_hi, 8'h00);
        chk1({tag, ".zero"}, zero, 1'b0);
        chk1({tag, ".carry"}, carry, 1'b0);
        chk1({tag, ".overflow"}, overflow, 1'b0);
        chk1({tag, ".err"}, err, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        t_op = '0; t_a = '0; t_b = '0;

        repeat (2) @(negedge clk);
        chk_cleared("reset");
        chk1("reset.in_ready", in_ready, 1'b1);
        align();
        rst = 1'b1;
        out_ready = 1'b1;

        send(4'd0, 8'h7F, 8'h01); @(negedge clk); lit_now("add_ovf", 8'h80, 8'h00, 0, 0, 1, 0); align();
        send(4'd0, 8'hFF, 8'h01); @(negedge clk); lit_now("add_carry", 8'h00, 8'h00, 1, 1, 0, 0); align();
        send(4'd1, 8'h03, 8'h05); @(negedge clk); lit_now("sub_borrow", 8'hFE, 8'h00, 0, 1, 0, 0); align();
        send(4'd6, 8'h80, 8'h01); @(negedge clk); lit_now("slt", 8'h01, 8'h00, 0, 0, 0, 0); align();
        send(4'd8, 8'h80, 8'h01); @(negedge clk); lit_now("sltu", 8'h00, 8'h00, 1, 0, 0, 0); align();
        send(4'd7, 8'h5A, 8'h5A); @(negedge clk); lit_now("eq", 8'h01, 8'h00, 0, 0, 0, 0); align();

        // MULU 0xFF*0xFF with a stray request held during the busy window
        send(4'd12, 8'hFF, 8'hFF);
        t_op = 4'd0; t_a = 8'h11; t_b = 8'h22; in_valid = 1'b1;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            chk1("mul_busy.in_ready", in_ready, 1'b0);
            chk1("mul_busy.out_valid", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        @(negedge clk); lit_now("mul_ff", 8'h01, 8'hFE, 0, 0, 1, 0); align();

        send(4'd12, 8'd13, 8'd11); wait_out(20); lit_now("mul_13x11", 8'h8F, 8'h00, 0, 0, 0, 0); align();

        // Back-to-back single-cycle ops, then consume + MULU accept
        send(4'd0, 8'h10, 8'h20);
        send(4'd1, 8'h50, 8'h10);
        @(negedge clk); lit_now("b2b_sub", 8'h40, 8'h00, 0, 0, 0, 0); align();
        send(4'd0, 8'h01, 8'h02);
        send(4'd12, 8'h03, 8'h04);
        @(negedge clk); chk1("mul_consume.out_valid", out_valid, 1'b0);
        wait_out(20); lit_now("mul_3x4", 8'h0C, 8'h00, 0, 0, 0, 0); align();

        // Backpressure: result held five cycles, then consume + new accept together
        out_ready = 1'b0;
        send(4'd4, 8'h0F, 8'hF0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("hold.in_ready", in_ready, 1'b0);
            chk1("hold.out_valid", out_valid, 1'b1);
            chk8("hold.y", y, 8'hFF);
        end
        align();
        out_ready = 1'b1;
        send(4'd5, 8'h3C, 8'h0F);
        @(negedge clk); lit_now("bp_xor", 8'h33, 8'h00, 0, 0, 0, 0); align();

        send(4'd11, 8'h90, 8'h03); @(negedge clk); lit_now("sra", 8'hF2, 8'h00, 0, 0, 0, 0); align();
        send(4'd10, 8'h90, 8'h03); @(negedge clk); lit_now("shr", 8'h12, 8'h00, 0, 0, 0, 0); align();
        send(4'd9, 8'h81, 8'h01);  @(negedge clk); lit_now("shl", 8'h02, 8'h00, 0, 0, 0, 0); align();
        send(4'd9, 8'hA5, 8'h08);  @(negedge clk); lit_now("shl_zero_amt", 8'hA5, 8'h00, 0, 0, 0, 0); align();
        send(4'd14, 8'h12, 8'h34); @(negedge clk); lit_now("illegal", 8'h00, 8'h00, 0, 0, 0, 1); align();

        // Sweep all opcodes on two operand pairs; the compare process checks each result
        for (int k = 0; k < 16; k++) send(4'(k), 8'hA5, 8'h3C);
        for (int k = 0; k < 16; k++) send(4'(k), 8'h80, 8'h7F);
        repeat (3) align();
        chk1("queue_drained", q.size() == 0, 1'b1);

        // Reset three cycles into a multiply
        send(4'd5, 8'hA5, 8'h3C);
        send(4'd12, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_cleared("mid_mul_reset");
        align();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk1("post_reset.out_valid", out_valid, 1'b0);
            chk1("post_reset.in_ready", in_ready, 1'b1);
            chk8("post_reset.y", y, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
